trng_byte_ctrl: RTL
===================

TRNG_BYTE_CTRL -- requirements
Module: trng_byte_ctrl

Interface
REQ-001 Parameter DEBIAS, default 1; 1 enables von Neumann pair debiasing, 0 passes raw bits directly.
REQ-002 Parameter REP_LIMIT, default 16; run length of identical raw bits that declares a health failure (range 2..255).
REQ-003 Parameter DISCARD_BYTES, default 2; bytes dropped after each start-up before any byte is presented (range 0..15).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 clear  in  1  reset; asynchronous, active-high.
REQ-006 enable  in  1  run request; low forces IDLE.
REQ-007 raw_bit  in  1  sampled ring-oscillator bit.
REQ-008 raw_valid  in  1  raw_bit qualifier; one bit per asserted cycle.
REQ-009 byte_out  out  8  assembled random byte.
REQ-010 byte_valid  out  1  byte_out holds an unconsumed byte.
REQ-011 byte_ready  in  1  consumer accepts byte_out when byte_valid is also high.
REQ-012 health_fail  out  1  sticky repetition-count failure flag.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 States are IDLE, WARMUP, COLLECT, HOLD and FAIL.
REQ-015 IDLE->WARMUP when enable=1 (or IDLE->COLLECT if DISCARD_BYTES=0); in every state except FAIL, enable=0 forces IDLE next cycle and discards the partial byte, the debias pair, any pending byte, and the warm-up count.
REQ-016 With DEBIAS=1, raw bits form pairs (a,b) in arrival order; a!=b yields one accepted bit equal to a; 00 and 11 yield nothing; the pair phase clears on IDLE.
REQ-017 With DEBIAS=0, every raw_valid cycle in WARMUP/COLLECT yields one accepted bit.
REQ-018 Accepted bits shift in at bit 0 of an 8-bit shift register, so the first accepted bit of a byte lands in byte_out[7].
REQ-019 A 3-bit counter counts accepted bits; the 8th accepted bit completes a byte and wraps the counter to 0.
REQ-020 In WARMUP, a completed byte is dropped and the warm-up count increments; on reaching DISCARD_BYTES the state moves to COLLECT.
REQ-021 In COLLECT, a completed byte loads byte_out, sets byte_valid on the next edge (latency 1 cycle after the 8th accepted bit), and the state moves to HOLD.
REQ-022 In HOLD, byte_out and byte_valid remain stable; raw bits are not debiased or shifted (lost) but still feed the health counter.
REQ-023 Transfer occurs on a cycle with byte_valid=1 and byte_ready=1; byte_valid is low on the next edge, the state returns to COLLECT, and bits are accepted from that next cycle.
REQ-024 The health counter tracks the run length of identical raw bits on raw_valid cycles in WARMUP, COLLECT and HOLD: same as previous -> +1 (saturating), different -> 1.
REQ-025 When the run length reaches REP_LIMIT, health_fail sets on that edge, byte_valid clears, byte_out becomes 0x00, and the state becomes FAIL.
REQ-026 FAIL ignores enable, raw_valid and byte_ready; it exits only via clear.
REQ-027 Health failure has priority over a byte completed or transferred in the same cycle; that byte is discarded.

Reset
REQ-028 clear asserted at any time, including mid-byte or in HOLD, immediately sets state=IDLE, byte_out=0x00, byte_valid=0, health_fail=0, busy=0, and all counters, shift register and pair phase to 0.
REQ-029 After clear deasserts, the first state change occurs at the first rising edge with enable=1.

Structure
REQ-030 Package trng_pkg holds the state enumeration, the BYTE_W=8 constant, and the parameter defaults.
REQ-031 Pair extraction is sub-module trng_vn_debias (in: bit, valid, flush; out: bit, valid); byte assembly and the FSM stay in trng_byte_ctrl.

Verification
REQ-032 DEBIAS=0, DISCARD_BYTES=0: raw 1,0,1,1,0,0,1,0 on consecutive cycles -> byte_out=0xB2, byte_valid high on the cycle after the 8th bit.
REQ-033 DEBIAS=1: pairs 10,01,10,10,01,01,10,01 interleaved with 00 and 11 pairs -> byte_out=0xB2.
REQ-034 DISCARD_BYTES=2, DEBIAS=0: 24 raw bits -> only the third byte is presented, and byte_valid stays low for the first 16 bits.
REQ-035 byte_ready low for 10 cycles with raw bits streaming -> byte_out stable; ready high for 1 cycle -> byte_valid low next cycle and the next byte is built from post-transfer bits only.
REQ-036 REP_LIMIT=16: 16 consecutive raw 1s -> health_fail=1 and byte_valid=0 after the 16th bit; enable toggling leaves FAIL; clear returns to IDLE.
REQ-037 Async clear pulsed between clock edges after 5 accepted bits -> outputs reset before the next edge, and the next byte needs 8 fresh bits.

Source files
------------

// File: rtl/trng_byte_ctrl_pkg.sv
// rtl/trng_byte_ctrl_pkg.sv - shared constants, parameter defaults and state encoding for the TRNG byte controller
package trng_pkg;

    localparam int BYTE_W            = 8;

    localparam int DEBIAS_DEF        = 1;
    localparam int REP_LIMIT_DEF     = 16;
    localparam int DISCARD_BYTES_DEF = 2;

    typedef logic [2:0] trng_state_t;

    localparam trng_state_t ST_IDLE    = 3'd0;
    localparam trng_state_t ST_WARMUP  = 3'd1;
    localparam trng_state_t ST_COLLECT = 3'd2;
    localparam trng_state_t ST_HOLD    = 3'd3;
    localparam trng_state_t ST_FAIL    = 3'd4;

endpackage

// File: rtl/trng_byte_ctrl_if.sv
// rtl/trng_byte_ctrl_if.sv - raw bit input, byte output handshake and status bundle
interface trng_byte_ctrl_if;
    import trng_pkg::*;

    logic              enable;
    logic              raw_bit;
    logic              raw_valid;
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              byte_ready;
    logic              health_fail;
    logic              busy;

    modport master (
        output enable, raw_bit, raw_valid, byte_ready,
        input  byte_out, byte_valid, health_fail, busy
    );

    modport slave (
        input  enable, raw_bit, raw_valid, byte_ready,
        output byte_out, byte_valid, health_fail, busy
    );

endinterface

// File: rtl/trng_vn_debias.sv
// rtl/trng_vn_debias.sv - von Neumann pair extractor: 01/10 pairs emit the first bit, 00/11 emit nothing
module trng_vn_debias (
    input  logic clk,
    input  logic clear,
    input  logic i_bit,
    input  logic i_valid,
    input  logic i_flush,
    output logic o_bit,
    output logic o_valid
);

    logic r_phase;
    logic r_first;

    // Track pair phase and hold the first bit of the pair until its partner arrives
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_phase <= 1'b0;
            r_first <= 1'b0;
        end else if (i_flush) begin
            r_phase <= 1'b0;
            r_first <= 1'b0;
        end else if (i_valid) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_first <= i_bit;
            end
        end
    end

    assign o_bit   = r_first;
    assign o_valid = i_valid && r_phase && !i_flush && (i_bit != r_first);

endmodule

// File: rtl/trng_byte_ctrl.sv
// rtl/trng_byte_ctrl.sv - TRNG byte assembler with warm-up discard, output hold and repetition-count health test
module trng_byte_ctrl
    import trng_pkg::*;
#(
    parameter int DEBIAS        = DEBIAS_DEF,
    parameter int REP_LIMIT     = REP_LIMIT_DEF,
    parameter int DISCARD_BYTES = DISCARD_BYTES_DEF
) (
    input logic              clk,
    input logic              clear,
    trng_byte_ctrl_if.slave  bus
);

    localparam logic [7:0] LP_REP_LIMIT = 8'(REP_LIMIT);
    localparam logic [3:0] LP_DISCARD   = 4'(DISCARD_BYTES);

    trng_state_t       r_state;
    logic [6:0]        r_shift;
    logic [2:0]        r_cnt;
    logic [3:0]        r_warm;
    logic [BYTE_W-1:0] r_byte_out;
    logic              r_byte_valid;
    logic              r_health_fail;
    logic [7:0]        r_run;
    logic              r_prev;

    logic              w_gather;
    logic              w_track;
    logic              w_flush;
    logic              w_vn_bit;
    logic              w_vn_valid;
    logic              w_acc_bit;
    logic              w_acc_valid;
    logic [BYTE_W-1:0] w_byte;
    logic              w_byte_done;
    logic [3:0]        w_warm_next;
    logic [7:0]        w_run_next;
    logic              w_fail_hit;

    // Bits are only gathered into bytes while warming up or collecting with the run request held
    assign w_gather = ((r_state == ST_WARMUP) || (r_state == ST_COLLECT)) && bus.enable;
    // Health tracking also watches the source while a byte is parked in HOLD
    assign w_track  = ((r_state == ST_WARMUP) || (r_state == ST_COLLECT) || (r_state == ST_HOLD))
                      && bus.raw_valid;
    // Pair phase is dropped whenever the controller is idle or about to be forced idle
    assign w_flush  = (r_state == ST_IDLE) || !bus.enable;

    trng_vn_debias u_vn_debias (
        .clk     (clk),
        .clear   (clear),
        .i_bit   (bus.raw_bit),
        .i_valid (bus.raw_valid && w_gather),
        .i_flush (w_flush),
        .o_bit   (w_vn_bit),
        .o_valid (w_vn_valid)
    );

    assign w_acc_bit   = (DEBIAS != 0) ? w_vn_bit   : bus.raw_bit;
    assign w_acc_valid = (DEBIAS != 0) ? w_vn_valid : (bus.raw_valid && w_gather);

    // First accepted bit ends up in the MSB once eight bits have been shifted in
    assign w_byte      = {r_shift, w_acc_bit};
    assign w_byte_done = w_acc_valid && (r_cnt == 3'd7);
    assign w_warm_next = r_warm + 4'd1;

    // Run length of identical raw bits, saturating so long runs cannot wrap below the limit
    always_comb begin
        w_run_next = 8'd1;
        if ((r_run != 8'd0) && (bus.raw_bit == r_prev)) begin
            w_run_next = (r_run == 8'hFF) ? r_run : (r_run + 8'd1);
        end
    end

    assign w_fail_hit = w_track && (w_run_next == LP_REP_LIMIT);

    // Repetition-count state, updated on every observed raw bit outside IDLE and FAIL
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_run  <= 8'd0;
            r_prev <= 1'b0;
        end else if (w_track) begin
            r_run  <= w_run_next;
            r_prev <= bus.raw_bit;
        end
    end

    // Main FSM: health failure outranks the run request, which outranks byte assembly and transfer
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state       <= ST_IDLE;
            r_shift       <= 7'd0;
            r_cnt         <= 3'd0;
            r_warm        <= 4'd0;
            r_byte_out    <= '0;
            r_byte_valid  <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (r_state == ST_FAIL) begin
            r_state <= ST_FAIL;
        end else if (w_fail_hit) begin
            r_state       <= ST_FAIL;
            r_health_fail <= 1'b1;
            r_byte_valid  <= 1'b0;
            r_byte_out    <= '0;
            r_shift       <= 7'd0;
            r_cnt         <= 3'd0;
        end else if (!bus.enable) begin
            r_state      <= ST_IDLE;
            r_shift      <= 7'd0;
            r_cnt        <= 3'd0;
            r_warm       <= 4'd0;
            r_byte_valid <= 1'b0;
            r_byte_out   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= (LP_DISCARD == 4'd0) ? ST_COLLECT : ST_WARMUP;
                end
                ST_WARMUP: begin
                    if (w_acc_valid) begin
                        r_shift <= w_byte[6:0];
                        r_cnt   <= r_cnt + 3'd1;
                    end
                    if (w_byte_done) begin
                        r_warm <= w_warm_next;
                        if (w_warm_next == LP_DISCARD) begin
                            r_state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (w_acc_valid) begin
                        r_shift <= w_byte[6:0];
                        r_cnt   <= r_cnt + 3'd1;
                    end
                    if (w_byte_done) begin
                        r_byte_out   <= w_byte;
                        r_byte_valid <= 1'b1;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.byte_ready) begin
                        r_byte_valid <= 1'b0;
                        r_state      <= ST_COLLECT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.byte_out    = r_byte_out;
    assign bus.byte_valid  = r_byte_valid;
    assign bus.health_fail = r_health_fail;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule
